// File: rtl/miss_handler_pkg.sv
// Shared widths, state encoding and status-row helpers for the instruction-cache miss handler.
package miss_handler_pkg;

    localparam int TAG_BITS_WIDTH    = 8;
    localparam int SET_BITS_WIDTH    = 4;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int NUM_BLOCKS        = 4;
    localparam int MEM_DATA_WIDTH    = 32;
    localparam int BEATS             = (2 ** BLOCK_OFFSET_BITS) * 8 / MEM_DATA_WIDTH;

    localparam int WAY_BITS      = 2;
    localparam int BEAT_BITS     = 2;
    localparam int ADDR_WIDTH    = TAG_BITS_WIDTH + SET_BITS_WIDTH + BLOCK_OFFSET_BITS;
    localparam int TA_ROW_WIDTH  = TAG_BITS_WIDTH * NUM_BLOCKS;
    localparam int SA_ROW_WIDTH  = 2 * NUM_BLOCKS;
    localparam int DA_ADDR_WIDTH = SET_BITS_WIDTH + WAY_BITS + BEAT_BITS;

    // Status row layout: each way owns a {use, valid} bit pair
    localparam int SA_VALID_BIT = 0;
    localparam int SA_USE_BIT   = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_FILL   = 2'b10,
        ST_UPDATE = 2'b11
    } mh_state_e;

    function automatic int sa_valid_idx(input int way);
        return 2 * way + SA_VALID_BIT;
    endfunction

    function automatic int sa_use_idx(input int way);
        return 2 * way + SA_USE_BIT;
    endfunction

    function automatic logic [TA_ROW_WIDTH-1:0] ta_row_insert(
        input logic [TA_ROW_WIDTH-1:0]   row,
        input logic [WAY_BITS-1:0]       way,
        input logic [TAG_BITS_WIDTH-1:0] tag
    );
        logic [TA_ROW_WIDTH-1:0] r;
        r = row;
        r[int'(way) * TAG_BITS_WIDTH +: TAG_BITS_WIDTH] = tag;
        return r;
    endfunction

endpackage

// File: rtl/miss_handler_if.sv
// Tag-check, memory and array-write bundle of the miss handler.
// CRITICAL_WORD_FIRST_EN adds the forward-data outputs.
interface miss_handler_if;
    import miss_handler_pkg::*;

    logic                         i_valid;
    logic                         i_cache_hit;
    logic [TAG_BITS_WIDTH-1:0]    i_tag_bits;
    logic [SET_BITS_WIDTH-1:0]    i_set_bits;
    logic [BLOCK_OFFSET_BITS-1:0] i_block_offset_bits;
    logic [TA_ROW_WIDTH-1:0]      i_ta_data;
    logic [SA_ROW_WIDTH-1:0]      i_status_array_data;
    logic                         o_halt;
    logic                         o_mem_req_valid;
    logic [ADDR_WIDTH-1:0]        o_mem_req_addr;
    logic                         i_mem_req_ready;
    logic                         i_mem_rsp_valid;
    logic [MEM_DATA_WIDTH-1:0]    i_mem_rsp_data;
    logic                         o_da_wr_en;
    logic [DA_ADDR_WIDTH-1:0]     o_da_wr_addr;
    logic [MEM_DATA_WIDTH-1:0]    o_da_wr_data;
    logic                         o_ta_wr_en;
    logic [SET_BITS_WIDTH-1:0]    o_ta_wr_set;
    logic [TA_ROW_WIDTH-1:0]      o_ta_wr_data;
    logic                         o_sa_wr_en;
    logic [SET_BITS_WIDTH-1:0]    o_sa_wr_set;
    logic [SA_ROW_WIDTH-1:0]      o_sa_wr_data;
    logic                         o_done;
`ifdef CRITICAL_WORD_FIRST_EN
    logic                         o_fwd_valid;
    logic [MEM_DATA_WIDTH-1:0]    o_fwd_data;
`endif

    modport slave (
`ifdef CRITICAL_WORD_FIRST_EN
        output o_fwd_valid, output o_fwd_data,
`endif
        input  i_valid, input i_cache_hit, input i_tag_bits, input i_set_bits,
        input  i_block_offset_bits, input i_ta_data, input i_status_array_data,
        output o_halt, output o_mem_req_valid, output o_mem_req_addr,
        input  i_mem_req_ready, input i_mem_rsp_valid, input i_mem_rsp_data,
        output o_da_wr_en, output o_da_wr_addr, output o_da_wr_data,
        output o_ta_wr_en, output o_ta_wr_set, output o_ta_wr_data,
        output o_sa_wr_en, output o_sa_wr_set, output o_sa_wr_data,
        output o_done
    );

    modport master (
`ifdef CRITICAL_WORD_FIRST_EN
        input  o_fwd_valid, input o_fwd_data,
`endif
        output i_valid, output i_cache_hit, output i_tag_bits, output i_set_bits,
        output i_block_offset_bits, output i_ta_data, output i_status_array_data,
        input  o_halt, input o_mem_req_valid, input o_mem_req_addr,
        output i_mem_req_ready, output i_mem_rsp_valid, output i_mem_rsp_data,
        input  o_da_wr_en, input o_da_wr_addr, input o_da_wr_data,
        input  o_ta_wr_en, input o_ta_wr_set, input o_ta_wr_data,
        input  o_sa_wr_en, input o_sa_wr_set, input o_sa_wr_data,
        input  o_done
    );

endinterface

// File: rtl/miss_handler_victim_select.sv
// Replacement choice for one set: first invalid way, else first not-recently-used way, else way 0,
// plus the status row to write back once that way is refilled.
module victim_select
    import miss_handler_pkg::*;
(
    input  logic [SA_ROW_WIDTH-1:0] status,
    output logic [WAY_BITS-1:0]     way,
    output logic [SA_ROW_WIDTH-1:0] status_next
);

    logic                inv_found_s;
    logic                unused_found_s;
    logic [WAY_BITS-1:0] inv_way_s;
    logic [WAY_BITS-1:0] unused_way_s;

    // Scan high-to-low so the lowest-index candidate is the one that survives
    always_comb begin
        inv_found_s    = 1'b0;
        unused_found_s = 1'b0;
        inv_way_s      = '0;
        unused_way_s   = '0;
        for (int w = NUM_BLOCKS - 1; w >= 0; w--) begin
            inv_found_s    = status[sa_valid_idx(w)] ? inv_found_s    : 1'b1;
            inv_way_s      = status[sa_valid_idx(w)] ? inv_way_s      : WAY_BITS'(w);
            unused_found_s = status[sa_use_idx(w)]   ? unused_found_s : 1'b1;
            unused_way_s   = status[sa_use_idx(w)]   ? unused_way_s   : WAY_BITS'(w);
        end
    end

    // Priority between the two scans
    always_comb begin
        way = '0;
        if (inv_found_s) begin
            way = inv_way_s;
        end else if (unused_found_s) begin
            way = unused_way_s;
        end else begin
            way = '0;
        end
    end

    // Mark the victim valid and used; once every way is used, only the victim keeps its use bit
    always_comb begin
        logic [SA_ROW_WIDTH-1:0] row_v;
        logic                    all_use_v;
        row_v     = status;
        all_use_v = 1'b1;
        for (int w = 0; w < NUM_BLOCKS; w++) begin
            row_v[sa_valid_idx(w)] = (WAY_BITS'(w) == way) ? 1'b1 : status[sa_valid_idx(w)];
            row_v[sa_use_idx(w)]   = (WAY_BITS'(w) == way) ? 1'b1 : status[sa_use_idx(w)];
        end
        for (int w = 0; w < NUM_BLOCKS; w++) begin
            all_use_v = all_use_v & row_v[sa_use_idx(w)];
        end
        for (int w = 0; w < NUM_BLOCKS; w++) begin
            row_v[sa_use_idx(w)] = (all_use_v && (WAY_BITS'(w) != way)) ? 1'b0 : row_v[sa_use_idx(w)];
        end
        status_next = row_v;
    end

endmodule

// File: rtl/miss_handler.sv
// Cache miss handler: stall, fetch the block beat by beat, fill the data array, then write tag and status rows.
// Build option CRITICAL_WORD_FIRST_EN: fetch starts at the missed word and forwards it.
module miss_handler
    import miss_handler_pkg::*;
(
    input  logic          clk,
    input  logic          arst_n,
    miss_handler_if.slave bus
);

    mh_state_e                 state_r;
    logic [TAG_BITS_WIDTH-1:0] tag_r;
    logic [SET_BITS_WIDTH-1:0] set_r;
    logic [TA_ROW_WIDTH-1:0]   ta_r;
    logic [WAY_BITS-1:0]       way_r;
    logic [SA_ROW_WIDTH-1:0]   sa_next_r;
    logic [BEAT_BITS-1:0]      beat_r;
    logic [BEAT_BITS-1:0]      beats_seen_r;

    logic                      halt_r;
    logic                      req_valid_r;
    logic [ADDR_WIDTH-1:0]     req_addr_r;
    logic                      ta_wr_en_r;
    logic [SET_BITS_WIDTH-1:0] ta_wr_set_r;
    logic [TA_ROW_WIDTH-1:0]   ta_wr_data_r;
    logic                      sa_wr_en_r;
    logic [SET_BITS_WIDTH-1:0] sa_wr_set_r;
    logic [SA_ROW_WIDTH-1:0]   sa_wr_data_r;
    logic                      done_r;

    logic                      miss_s;
    logic                      rsp_fire_s;
    logic [BEAT_BITS-1:0]      first_beat_s;
    logic [WAY_BITS-1:0]       vs_way_s;
    logic [SA_ROW_WIDTH-1:0]   vs_status_s;
    logic [MEM_DATA_WIDTH-1:0] da_data_s;

    victim_select u_victim_select (
        .status      (bus.i_status_array_data),
        .way         (vs_way_s),
        .status_next (vs_status_s)
    );

    assign miss_s     = bus.i_valid & ~bus.i_cache_hit;
    assign rsp_fire_s = (state_r == ST_FILL) & bus.i_mem_rsp_valid;

`ifdef CRITICAL_WORD_FIRST_EN
    assign first_beat_s = bus.i_block_offset_bits[BLOCK_OFFSET_BITS-1 -: BEAT_BITS];
`else
    assign first_beat_s = 2'b00;
`endif

    // Miss sequencing: capture, request, count beats, then a single tag/status update cycle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r      <= ST_IDLE;
            tag_r        <= '0;
            set_r        <= '0;
            ta_r         <= '0;
            way_r        <= '0;
            sa_next_r    <= '0;
            beat_r       <= '0;
            beats_seen_r <= '0;
            halt_r       <= 1'b0;
            req_valid_r  <= 1'b0;
            req_addr_r   <= '0;
            ta_wr_en_r   <= 1'b0;
            ta_wr_set_r  <= '0;
            ta_wr_data_r <= '0;
            sa_wr_en_r   <= 1'b0;
            sa_wr_set_r  <= '0;
            sa_wr_data_r <= '0;
            done_r       <= 1'b0;
        end else begin
            ta_wr_en_r <= 1'b0;
            sa_wr_en_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (miss_s) begin
                        tag_r        <= bus.i_tag_bits;
                        set_r        <= bus.i_set_bits;
                        ta_r         <= bus.i_ta_data;
                        way_r        <= vs_way_s;
                        sa_next_r    <= vs_status_s;
                        beat_r       <= first_beat_s;
                        beats_seen_r <= '0;
                        req_addr_r   <= {bus.i_tag_bits, bus.i_set_bits, first_beat_s, 2'b00};
                        req_valid_r  <= 1'b1;
                        halt_r       <= 1'b1;
                        state_r      <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.i_mem_req_ready) begin
                        req_valid_r <= 1'b0;
                        state_r     <= ST_FILL;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_FILL: begin
                    if (bus.i_mem_rsp_valid) begin
                        beat_r       <= beat_r + 2'd1;
                        beats_seen_r <= beats_seen_r + 2'd1;
                        if (beats_seen_r == 2'(BEATS - 1)) begin
                            // Status goes out last so an aborted refill never marks the way valid
                            ta_wr_en_r   <= 1'b1;
                            ta_wr_set_r  <= set_r;
                            ta_wr_data_r <= ta_row_insert(ta_r, way_r, tag_r);
                            sa_wr_en_r   <= 1'b1;
                            sa_wr_set_r  <= set_r;
                            sa_wr_data_r <= sa_next_r;
                            done_r       <= 1'b1;
                            state_r      <= ST_UPDATE;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_UPDATE: begin
                    halt_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    halt_r      <= 1'b0;
                    req_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Data-array write follows the response beat in the same cycle
    always_comb begin
        da_data_s = '0;
        if (rsp_fire_s) begin
            da_data_s = bus.i_mem_rsp_data;
        end else begin
            da_data_s = '0;
        end
    end

    assign bus.o_halt          = halt_r;
    assign bus.o_mem_req_valid = req_valid_r;
    assign bus.o_mem_req_addr  = req_addr_r;
    assign bus.o_da_wr_en      = rsp_fire_s;
    assign bus.o_da_wr_addr    = {set_r, way_r, beat_r};
    assign bus.o_da_wr_data    = da_data_s;
    assign bus.o_ta_wr_en      = ta_wr_en_r;
    assign bus.o_ta_wr_set     = ta_wr_set_r;
    assign bus.o_ta_wr_data    = ta_wr_data_r;
    assign bus.o_sa_wr_en      = sa_wr_en_r;
    assign bus.o_sa_wr_set     = sa_wr_set_r;
    assign bus.o_sa_wr_data    = sa_wr_data_r;
    assign bus.o_done          = done_r;

`ifdef CRITICAL_WORD_FIRST_EN
    logic fwd_valid_s;
    assign fwd_valid_s     = rsp_fire_s & (beats_seen_r == 2'd0);
    assign bus.o_fwd_valid = fwd_valid_s;
    assign bus.o_fwd_data  = fwd_valid_s ? bus.i_mem_rsp_data : '0;
`endif

endmodule
